shift_serializer: RTL and testbench

//  Parallel-to-serial shift stage built on posedge-clocked, ClrN-cleared D flip-flops.

---
 rtl/shift_serializer.sv | 128 ++++++++++++
 tb/tb_shift_serializer.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/shift_serializer.sv
// Parallel-to-serial shift stage: accepts a WIDTH-bit word through Load/Ready and
// emits it one registered bit per clock on SerOut, qualified by SerValid, with Stall.
module shift_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b0,
    localparam int CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic             Clk,
    input  logic             ClrN,
    input  logic             Load,
    input  logic [WIDTH-1:0] DataIn,
    input  logic             Stall,
    output logic             Ready,
    output logic             SerOut,
    output logic             SerValid,
    output logic             Done,
    output logic [CW-1:0]    BitCnt
);

    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            state_reg,     state_next;
    logic [WIDTH-1:0]  shreg_reg,     shreg_next;
    logic              ser_out_reg,   ser_out_next;
    logic              ser_valid_reg, ser_valid_next;
    logic              done_reg,      done_next;
    logic              ready_reg,     ready_next;
    logic [CW-1:0]     bit_cnt_reg,   bit_cnt_next;

    // Word reordered so the first bit to emit sits at index 0; the register always shifts right.
    logic [WIDTH-1:0]  din_ord;

    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_order
            if (MSB_FIRST) begin : g_msb
                assign din_ord[gi] = DataIn[WIDTH-1-gi];
            end else begin : g_lsb
                assign din_ord[gi] = DataIn[gi];
            end
        end
    endgenerate

    always_ff @(posedge Clk or negedge ClrN) begin
        if (!ClrN) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            ser_out_reg   <= 1'b0;
            ser_valid_reg <= 1'b0;
            done_reg      <= 1'b0;
            ready_reg     <= 1'b1;
            bit_cnt_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            shreg_reg     <= shreg_next;
            ser_out_reg   <= ser_out_next;
            ser_valid_reg <= ser_valid_next;
            done_reg      <= done_next;
            ready_reg     <= ready_next;
            bit_cnt_reg   <= bit_cnt_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        shreg_next     = shreg_reg;
        ser_out_next   = ser_out_reg;
        ser_valid_next = ser_valid_reg;
        done_next      = 1'b0;
        ready_next     = ready_reg;
        bit_cnt_next   = bit_cnt_reg;

        case (state_reg)
            IDLE: begin
                if (Load) begin
                    // First bit goes straight to SerOut; the rest waits in the shift register.
                    shreg_next     = {1'b0, din_ord[WIDTH-1:1]};
                    ser_out_next   = din_ord[0];
                    ser_valid_next = 1'b1;
                    bit_cnt_next   = '0;
                    ready_next     = 1'b0;
                    state_next     = SHIFT;
                end
            end
            SHIFT: begin
                if (!Stall) begin
                    if (bit_cnt_reg == LAST_IDX) begin
                        shreg_next     = '0;
                        ser_out_next   = 1'b0;
                        ser_valid_next = 1'b0;
                        done_next      = 1'b1;
                        bit_cnt_next   = '0;
                        state_next     = DONE;
                    end else begin
                        ser_out_next = shreg_reg[0];
                        shreg_next   = shreg_reg >> 1;
                        bit_cnt_next = bit_cnt_reg + CW'(1);
                    end
                end
            end
            DONE: begin
                ready_next = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next     = IDLE;
                shreg_next     = '0;
                ser_out_next   = 1'b0;
                ser_valid_next = 1'b0;
                ready_next     = 1'b1;
                bit_cnt_next   = '0;
            end
        endcase
    end

    assign Ready    = ready_reg;
    assign SerOut   = ser_out_reg;
    assign SerValid = ser_valid_reg;
    assign Done     = done_reg;
    assign BitCnt   = bit_cnt_reg;

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer: an LSB-first and an MSB-first instance share
// stimulus; a negedge monitor pops expected {bit, index} pairs whenever SerValid is high.
`timescale 1ns/1ps
module tb_shift_serializer;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       load;
    logic       stall;
    logic [7:0] data_in;

    logic       ready0, ser_out0, ser_valid0, done0;
    logic [2:0] bit_cnt0;
    logic       ready1, ser_out1, ser_valid1, done1;
    logic [2:0] bit_cnt1;

    int n_checks = 0;
    int n_errors = 0;

    // Expected {SerOut, BitCnt} per valid cycle, one queue per instance
    logic [3:0] q0[$];
    logic [3:0] q1[$];
    logic [3:0] e0, e1;

    always #50 clk = ~clk;

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut0 (
        .Clk(clk), .ClrN(clr_n), .Load(load), .DataIn(data_in), .Stall(stall),
        .Ready(ready0), .SerOut(ser_out0), .SerValid(ser_valid0), .Done(done0), .BitCnt(bit_cnt0)
    );

    shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) dut1 (
        .Clk(clk), .ClrN(clr_n), .Load(load), .DataIn(data_in), .Stall(stall),
        .Ready(ready1), .SerOut(ser_out1), .SerValid(ser_valid1), .Done(done1), .BitCnt(bit_cnt1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " dut0 Ready"},    ready0,     1);
        check({name, " dut0 SerValid"}, ser_valid0, 0);
        check({name, " dut0 SerOut"},   ser_out0,   0);
        check({name, " dut0 Done"},     done0,      0);
        check({name, " dut0 BitCnt"},   bit_cnt0,   0);
        check({name, " dut1 Ready"},    ready1,     1);
        check({name, " dut1 SerValid"}, ser_valid1, 0);
        check({name, " dut1 Done"},     done1,      0);
    endtask

    // Expected bit stream; the stalled index is repeated for the stall length.
    task automatic push_exp(input logic [7:0] w, input int stall_at, input int stall_len);
        for (int c = 0; c < 8; c++) begin
            int reps;
            reps = (c == stall_at) ? 1 + stall_len : 1;
            for (int r = 0; r < reps; r++) begin
                q0.push_back({w[c],     3'(c)});
                q1.push_back({w[7 - c], 3'(c)});
            end
        end
    endtask

    // Entered #1 after an edge with both instances in IDLE.
    task automatic run_frame(input string tag, input logic [7:0] w, input int stall_at,
                             input int stall_len, input bit hold_load);
        $display("frame %s: word=%02h stall_at=%0d stall_len=%0d hold_load=%0b",
                 tag, w, stall_at, stall_len, hold_load);
        push_exp(w, stall_at, stall_len);
        stall   = 1'b1;           // no effect while idle
        load    = 1'b1;
        data_in = w;
        @(posedge clk); #1;
        load    = hold_load;
        data_in = 8'h00;          // captured word must not follow DataIn
        stall   = 1'b0;
        check({tag, " Ready low after accept"}, ready0, 0);
        for (int c = 0; c < 8; c++) begin
            if (c == stall_at) begin
                stall = 1'b1;
                repeat (stall_len) begin
                    @(posedge clk); #1;
                    check({tag, " no Done while stalled"}, done0, 0);
                    check({tag, " Ready low while stalled"}, ready0, 0);
                end
                stall = 1'b0;
            end
            @(posedge clk); #1;
            if (c < 7) begin
                check({tag, " no early Done"}, done0, 0);
                check({tag, " SerValid in frame"}, ser_valid0, 1);
            end
        end
        check({tag, " dut0 Done pulse"},    done0,      1);
        check({tag, " dut1 Done pulse"},    done1,      1);
        check({tag, " SerValid low in DONE"}, ser_valid0, 0);
        check({tag, " SerOut low in DONE"},  ser_out0,   0);
        check({tag, " BitCnt zero in DONE"}, bit_cnt0,   0);
        check({tag, " Ready low in DONE"},   ready0,     0);
        stall = 1'b1;             // no effect in DONE
        @(posedge clk); #1;
        stall = 1'b0;
        check({tag, " Done one cycle"},    done0,  0);
        check({tag, " Ready after DONE"},  ready0, 1);
        check({tag, " dut1 Ready after DONE"}, ready1, 1);
    endtask

    always @(negedge clk) begin
        if (ser_valid0) begin
            if (q0.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL dut0 unexpected bit: got SerOut=%0b BitCnt=%0d, expected no valid bit",
                         ser_out0, bit_cnt0);
            end else begin
                e0 = q0.pop_front();
                check("dut0 serial {bit,cnt}", {28'd0, ser_out0, bit_cnt0}, {28'd0, e0});
            end
        end
        if (ser_valid1) begin
            if (q1.size() == 0) begin
                n_checks++; n_errors++;
                $display("FAIL dut1 unexpected bit: got SerOut=%0b BitCnt=%0d, expected no valid bit",
                         ser_out1, bit_cnt1);
            end else begin
                e1 = q1.pop_front();
                check("dut1 serial {bit,cnt}", {28'd0, ser_out1, bit_cnt1}, {28'd0, e1});
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset held with Load=1 and a running clock: nothing accepted
        clr_n   = 1'b0;
        load    = 1'b1;
        stall   = 1'b0;
        data_in = 8'hFF;
        repeat (3) begin
            @(negedge clk);
            check_reset_outputs("reset hold");
        end
        load = 1'b0;
        #25 clr_n = 1'b1;
        @(posedge clk); #1;
        check_reset_outputs("after reset release");

        run_frame("A5 basic", 8'hA5, -1, 0, 1'b0);
        run_frame("0F stall", 8'h0F, 3, 3, 1'b0);

        // Load held high through two frames
        run_frame("FF held", 8'hFF, -1, 0, 1'b1);
        run_frame("00 held", 8'h00, -1, 0, 1'b1);
        load = 1'b0;
        @(posedge clk); #1;
        check("no accept after Load drop", ready0, 1);

        // Abort mid-frame with a short ClrN pulse between edges
        $display("frame 5A abort: word=5a reset pulse at BitCnt=4");
        push_exp(8'h5A, -1, 0);
        load    = 1'b1;
        data_in = 8'h5A;
        @(posedge clk); #1;
        load = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        check("abort BitCnt before pulse", bit_cnt0, 4);
        #59 clr_n = 1'b0;
        #1 check_reset_outputs("async reset");
        #19 clr_n = 1'b1;
        q0.delete();
        q1.delete();
        check_reset_outputs("after abort");
        run_frame("36 after abort", 8'h36, -1, 0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        check("dut0 scoreboard drained", q0.size(), 0);
        check("dut1 scoreboard drained", q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
